// File: rtl/gemv_pkg.sv
// Shared types and helpers for the GEMV tile scheduler.
package gemv_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int TILE_SIZE_DEF  = 32;
    localparam int DIM_W          = 10;   // rows / cols field width
    localparam int CNT_W          = 16;   // tile counters

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        START,
        STREAM,
        WAIT_DONE,
        DONE
    } sched_state_e;

    // ceil(cols / 2**tile_log2); the sum stays well inside CNT_W for 10-bit cols
    function automatic logic [CNT_W-1:0] tiles_per_row(input logic [DIM_W-1:0] cols,
                                                       input int tile_log2);
        logic [CNT_W-1:0] sum;
        sum = CNT_W'(cols) + CNT_W'((1 << tile_log2) - 1);
        return sum >> tile_log2;
    endfunction

endpackage

// File: rtl/tile_fifo.sv
// Small synchronous FIFO holding prefetched weight tiles; head is shown
// combinationally so the scheduler can present it without a bubble.
module tile_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 256,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [PW:0]      count,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is only accepted when the head leaves the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // storage, pointers and occupancy; flush drops all contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/gemv_tile_scheduler.sv
// Sequences one GEMV layer: accepts a command, starts the datapath, prefetches
// weight tiles into a small FIFO and streams them row-major, then reports done.
module gemv_tile_scheduler
    import gemv_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TILE_SIZE      = TILE_SIZE_DEF,
    parameter int ADDR_WIDTH     = 16,
    parameter int PREFETCH_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [9:0]                      cmd_rows,
    input  logic [9:0]                      cmd_cols,
    input  logic [ADDR_WIDTH-1:0]           cmd_w_base,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    input  logic                            mem_rd_valid,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] mem_rd_data,
    output logic                            gemv_start,
    input  logic                            gemv_w_ready,
    output logic                            gemv_w_valid,
    output logic [TILE_SIZE*DATA_WIDTH-1:0] gemv_w_tile,
    input  logic                            gemv_done,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int TW        = TILE_SIZE * DATA_WIDTH;
    localparam int PW        = $clog2(PREFETCH_DEPTH);
    localparam int TILE_LOG2 = $clog2(TILE_SIZE);

    sched_state_e          state, state_nx;
    logic [CNT_W-1:0]      total_q, req_cnt, sent_cnt, sent_nx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [PW:0]           inflight, fifo_count;
    logic [TW-1:0]         fifo_head;
    logic                  err_q, done_seen;
    logic                  fifo_empty, accept, bad_cmd, issue_phase;
    logic                  ret, push, pop, flush;

    assign accept  = (state == IDLE) && cmd_valid;
    assign bad_cmd = (cmd_rows == '0) || (cmd_cols == '0);

    // returns with nothing outstanding (after reset or a discard) are stale
    assign ret     = mem_rd_valid && (inflight != '0);
    assign push    = ret && issue_phase;
    assign pop     = gemv_w_valid;
    assign flush   = (state == STREAM) && gemv_done;
    assign sent_nx = sent_cnt + CNT_W'(pop);

    // FIFO slots plus outstanding reads never exceed the FIFO depth, so it cannot overflow
    assign mem_rd_en   = issue_phase && (req_cnt < total_q) &&
                         ((PW+2)'(fifo_count) + (PW+2)'(inflight) < (PW+2)'(PREFETCH_DEPTH));
    assign mem_rd_addr = base_q + ADDR_WIDTH'(req_cnt);

    // the datapath samples w_valid without looking at its own ready, so ready gates it here
    assign gemv_w_valid = (state == STREAM) && !fifo_empty && gemv_w_ready;
    assign gemv_w_tile  = fifo_head;
    assign err          = err_q;

    tile_fifo #(
        .DEPTH (PREFETCH_DEPTH),
        .WIDTH (TW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (mem_rd_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head),
        .empty     (fifo_empty)
    );

    // state register, command latch and tile/inflight bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            total_q   <= '0;
            req_cnt   <= '0;
            sent_cnt  <= '0;
            base_q    <= '0;
            inflight  <= '0;
            err_q     <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            state     <= state_nx;
            done_seen <= (state == DONE);
            inflight  <= inflight + (PW+1)'(mem_rd_en) - (PW+1)'(ret);
            if (accept) begin
                base_q   <= cmd_w_base;
                total_q  <= CNT_W'(cmd_rows) * tiles_per_row(cmd_cols, TILE_LOG2);
                req_cnt  <= '0;
                sent_cnt <= '0;
                err_q    <= bad_cmd;
            end else begin
                if (mem_rd_en) req_cnt <= req_cnt + 1'b1;
                sent_cnt <= sent_nx;
                if (flush) err_q <= 1'b1;
            end
        end
    end

    // next state and per-state control outputs
    always_comb begin
        state_nx    = state;
        cmd_ready   = 1'b0;
        gemv_start  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        issue_phase = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nx = bad_cmd ? ERR : START;
            end
            ERR: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            START: begin
                gemv_start  = 1'b1;
                issue_phase = 1'b1;
                state_nx    = STREAM;
            end
            STREAM: begin
                issue_phase = 1'b1;
                if (gemv_done)               state_nx = DONE;
                else if (sent_nx == total_q) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (gemv_done) state_nx = DONE;
            end
            DONE: begin
                // after an early gemv_done, linger until every outstanding read has come back
                done = !done_seen;
                if (inflight == '0 || (inflight == (PW+1)'(1) && ret)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gemv_tile_scheduler.sv
// Directed bench for gemv_tile_scheduler: a table of layer commands plus
// hand-written stall, early-done and mid-stream reset sequences.
module tb_gemv_tile_scheduler;

    localparam int DW = 8;
    localparam int TS = 32;
    localparam int AW = 16;
    localparam int PD = 2;
    localparam int TW = DW * TS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [9:0]    cmd_rows = '0;
    logic [9:0]    cmd_cols = '0;
    logic [AW-1:0] cmd_w_base = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_valid;
    logic [TW-1:0] mem_rd_data;
    logic          gemv_start;
    logic          gemv_w_ready = 1'b0;
    logic          gemv_w_valid;
    logic [TW-1:0] gemv_w_tile;
    logic          gemv_done = 1'b0;
    logic          busy, done, err;

    always #5 clk = ~clk;

    gemv_tile_scheduler #(
        .DATA_WIDTH(DW), .TILE_SIZE(TS), .ADDR_WIDTH(AW), .PREFETCH_DEPTH(PD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_w_base(cmd_w_base),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .gemv_start(gemv_start), .gemv_w_ready(gemv_w_ready),
        .gemv_w_valid(gemv_w_valid), .gemv_w_tile(gemv_w_tile),
        .gemv_done(gemv_done), .busy(busy), .done(done), .err(err)
    );

    // weight memory content is a function of the address
    function automatic logic [TW-1:0] tile_for(input logic [AW-1:0] a);
        return {8{a, ~a}};
    endfunction

    // memory model: fixed latency 1..4, in order, never reset
    int            lat = 1;
    logic [4:1]    pv = '0;
    logic [AW-1:0] pa [1:4];
    always @(posedge clk) begin
        pv    <= {pv[3:1], mem_rd_en};
        pa[4] <= pa[3];
        pa[3] <= pa[2];
        pa[2] <= pa[1];
        pa[1] <= mem_rd_addr;
    end
    assign mem_rd_valid = pv[lat];
    assign mem_rd_data  = tile_for(pa[lat]);

    // cumulative activity log; tests snapshot positions instead of clearing
    logic [AW-1:0] rd_log [$];
    logic [TW-1:0] xf_log [$];
    int n_start = 0;
    int n_vwr   = 0;
    always @(posedge clk) begin
        if (mem_rd_en) rd_log.push_back(mem_rd_addr);
        if (gemv_w_valid && gemv_w_ready) xf_log.push_back(gemv_w_tile);
        if (gemv_start) n_start <= n_start + 1;
        if (gemv_w_valid && !gemv_w_ready) n_vwr <= n_vwr + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]    rows;
        logic [9:0]    cols;
        logic [AW-1:0] base;
        int            lat;
        int            total;
        logic [AW-1:0] last;
        logic          err;
    } vec_t;

    vec_t vt [7];

    // called on a negedge; returns on the negedge after the accepting edge
    task automatic issue(input logic [9:0] r, input logic [9:0] c, input logic [AW-1:0] b);
        cmd_valid  = 1'b1;
        cmd_rows   = r;
        cmd_cols   = c;
        cmd_w_base = b;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // wait for all tiles, complete the layer, then check reads/transfers/order
    task automatic finish_run(input int total, input logic [AW-1:0] base,
                              input int rd0, input int xf0, input string tag);
        int cyc;
        int bad;
        cyc = 0;
        while (xf_log.size() - xf0 < total && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".tiles_in_time"}, 32'(cyc < 400), 1);
        repeat (3) @(negedge clk);
        chk({tag, ".no_valid_wait"}, 32'(gemv_w_valid), 0);
        gemv_done = 1'b1;
        @(negedge clk);
        gemv_done = 1'b0;
        chk({tag, ".done_pulse"}, {30'd0, done, busy}, 32'h3);
        @(negedge clk);
        chk({tag, ".done_drop"}, {30'd0, done, busy}, 32'h0);
        chk({tag, ".reads"}, 32'(rd_log.size() - rd0), 32'(total));
        chk({tag, ".xfers"}, 32'(xf_log.size() - xf0), 32'(total));
        bad = 0;
        for (int k = 0; k < total; k++) begin
            if (rd_log[rd0 + k] !== AW'(base + AW'(k))) bad++;
            if (xf_log[xf0 + k] !== tile_for(AW'(base + AW'(k)))) bad++;
        end
        chk({tag, ".order"}, 32'(bad), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rd0, xf0, st0;
        lat          = v.lat;
        gemv_w_ready = 1'b1;
        @(negedge clk);
        rd0 = rd_log.size();
        xf0 = xf_log.size();
        st0 = n_start;
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
        issue(v.rows, v.cols, v.base);
        if (v.err) begin
            chk({tag, ".err_cycle"}, {28'd0, err, done, busy, gemv_start}, 32'he);
            @(negedge clk);
            chk({tag, ".err_after"}, {29'd0, err, done, busy}, 32'h4);
            chk({tag, ".err_reads"}, 32'(rd_log.size() - rd0), 0);
            chk({tag, ".err_starts"}, 32'(n_start - st0), 0);
        end else begin
            chk({tag, ".start"}, {30'd0, gemv_start, busy}, 32'h3);
            finish_run(v.total, v.base, rd0, xf0, tag);
            chk({tag, ".last_addr"}, 32'(rd_log[rd_log.size() - 1]), 32'(v.last));
            chk({tag, ".starts"}, 32'(n_start - st0), 1);
            chk({tag, ".err_clear"}, 32'(err), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd0, xf0, o, maxo, cyc;
        vt[0] = '{10'd4, 10'd64,  16'h0100, 1, 8, 16'h0107, 1'b0};
        vt[1] = '{10'd3, 10'd33,  16'h0200, 1, 6, 16'h0205, 1'b0};
        vt[2] = '{10'd0, 10'd17,  16'h0000, 1, 0, 16'h0000, 1'b1};
        vt[3] = '{10'd2, 10'd64,  16'hFFFE, 1, 4, 16'h0001, 1'b0};
        vt[4] = '{10'd1, 10'd1,   16'h0010, 2, 1, 16'h0010, 1'b0};
        vt[5] = '{10'd5, 10'd0,   16'h0700, 1, 0, 16'h0000, 1'b1};
        vt[6] = '{10'd2, 10'd32,  16'h0800, 3, 2, 16'h0801, 1'b0};

        // reset values
        repeat (2) @(negedge clk);
        chk("reset.ctrl", {25'd0, cmd_ready, busy, done, err, mem_rd_en, gemv_start, gemv_w_valid},
            32'h40);
        chk("reset.addr", 32'(mem_rd_addr), 0);
        chk("reset.tile", 32'(gemv_w_tile == '0), 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // latency 3 with the datapath stalled: prefetch must stop at the FIFO depth
        lat          = 3;
        gemv_w_ready = 1'b0;
        @(negedge clk);
        rd0 = rd_log.size();
        xf0 = xf_log.size();
        issue(10'd2, 10'd128, 16'h0300);
        maxo = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) begin
                cmd_valid = 1'b1;
                cmd_rows  = 10'd0;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            o = (rd_log.size() - rd0) - (xf_log.size() - xf0);
            if (o > maxo) maxo = o;
        end
        cmd_valid = 1'b0;
        chk("stall.max_outstanding", 32'(maxo), 2);
        chk("stall.reads", 32'(rd_log.size() - rd0), 2);
        chk("stall.no_xfer", 32'(xf_log.size() - xf0), 0);
        chk("stall.busy_cmd_ignored", {29'd0, busy, cmd_ready, err}, 32'h4);
        gemv_w_ready = 1'b1;
        finish_run(8, 16'h0300, rd0, xf0, "stall");

        // gemv_done arriving mid-stream: err, one done pulse, back to IDLE
        lat          = 1;
        gemv_w_ready = 1'b0;
        @(negedge clk);
        issue(10'd4, 10'd32, 16'h0600);
        repeat (5) @(negedge clk);
        gemv_done = 1'b1;
        @(negedge clk);
        gemv_done = 1'b0;
        chk("early.done_err", {29'd0, err, done, busy}, 32'h7);
        chk("early.no_valid", 32'(gemv_w_valid), 0);
        cyc = 0;
        while (!cmd_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("early.back_idle", {29'd0, cmd_ready, done, err}, 32'h5);
        run_vec(vt[1], "after_early");

        // reset with one read in flight; its late return must not reach the FIFO
        lat          = 3;
        gemv_w_ready = 1'b1;
        @(negedge clk);
        issue(10'd4, 10'd32, 16'h0400);
        @(negedge clk);
        chk("rst.pre_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst.async", {25'd0, cmd_ready, busy, done, err, mem_rd_en, gemv_start, gemv_w_valid},
            32'h40);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_vec('{10'd1, 10'd64, 16'h0500, 3, 2, 16'h0501, 1'b0}, "post_rst");

        chk("valid_without_ready", 32'(n_vwr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
